// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: PC/instruction widths, bubble encoding, fetch FSM states, queue entry.
// Latency: none (types and a pure helper function only).
// Backpressure: not applicable.
package riscv_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  // Encoding decode treats as a no-op when nothing valid is presented.
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 16'h0001;

  // IDLE: nothing outstanding. WAIT: outstanding, response is wanted.
  // DISCARD: outstanding, response belongs to a flushed path and is dropped.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at the top of the PC space.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc, instr} entries with a flush that empties it in one cycle.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller must never push when full, pop is ignored when empty.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  fetch_entry_t             push_dat_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     head_vld_o,
  output fetch_entry_t             head_dat_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 do_pop;

  assign do_pop     = pop_i && (count_q != '0);
  assign count_o    = count_q;
  assign head_vld_o = (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; flush discards everything, including same-cycle push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one-outstanding memory requester feeding a prefetch queue toward decode.
// Latency: fetch-to-decode is memory latency + 1 cycle; redirect flushes and refetches next cycle.
// Backpressure: id_ready low holds the head; requests stop once the queue is full.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc
);

  localparam int             CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetch_state_e     state_q;
  logic [PC_W-1:0]  fetch_pc_q;
  logic [PC_W-1:0]  req_pc_q;

  logic [CNT_W-1:0] count;
  logic             head_vld;
  fetch_entry_t     head_dat;
  fetch_entry_t     push_entry;
  logic             fetch_req;
  logic             rsp_push;
  logic             id_pop;

  // Request/push/pop decode. The request must see this cycle's redirect and reset, so it is
  // combinational; counting only completed entries is safe because at most one is in flight.
  always_comb begin
    fetch_req = (state_q == IDLE) && (count < DEPTH_CNT) && !redirect_valid && !reset;
    rsp_push  = (state_q == WAIT) && imem_rvalid && !redirect_valid;
    id_pop    = head_vld && id_ready;
  end

  assign imem_req   = fetch_req;
  assign imem_addr  = fetch_pc_q;
  assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

  // Fetch FSM with fetch/request PC tracking. A response arriving together with a redirect
  // completes the outstanding request, so the FSM returns to IDLE instead of waiting for
  // a response that has already come back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_req) begin
            state_q    <= WAIT;
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= pc_next(fetch_pc_q);
          end
        end
        WAIT: begin
          if (imem_rvalid)         state_q <= IDLE;
          else if (redirect_valid) state_q <= DISCARD;
        end
        DISCARD: begin
          if (imem_rvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (redirect_valid) fetch_pc_q <= redirect_pc;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_fetch_queue (
    .clock     (clock),
    .reset     (reset),
    .push_i    (rsp_push),
    .push_dat_i(push_entry),
    .pop_i     (id_pop),
    .flush_i   (redirect_valid),
    .count_o   (count),
    .head_vld_o(head_vld),
    .head_dat_o(head_dat)
  );

  assign id_valid = head_vld;
  assign id_instr = head_vld ? head_dat.instr : BUBBLE_INSTR;
  assign id_pc    = head_vld ? head_dat.pc    : '0;

endmodule
